data_mem_unit: RTL and testbench

Multi-cycle data-memory stage sitting directly downstream of the ALU in the single-cycle datapath. Takes the ALU result as the effective address, plus the store data and memory control, and performs byte/halfword/word loads and stores against an internal word array with a fixed wait-state count. Holds the core with `stall` while the access is in flight and presents load data aligned and extended for write-back.

---
 rtl/data_mem_unit.sv | 181 ++++++++++++++++++
 tb/tb_data_mem_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// data_mem_unit: multi-cycle data-memory stage (byte/half/word load/store,
// fixed wait states, stall/done handshake).
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (reject misaligned requests).
module data_mem_unit #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    size_q, size_d;
  logic          lu_q, lu_d;
  logic          wr_q, wr_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          req;
  logic          bad;
  logic [AW+1:0] addr_n;
  logic [1:0]    size_n;
  logic [31:0]   word_rd;
  logic [31:0]   wr_val;
  logic [31:0]   ld_val;
  logic [3:0]    be;
  logic          mem_we;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^addr[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    req    = mem_read | mem_write;
    bad    = (size == 2'b01 && addr[0]) ||
             (size == 2'b10 && addr[1:0] != 2'b00) ||
             (size == 2'b11);
    addr_n = addr[AW+1:0];
    size_n = size;
  end
`else
  // Without trapping, misaligned low bits are dropped and size 11 acts as word.
  always_comb begin
    req    = mem_read | mem_write;
    bad    = 1'b0;
    addr_n = addr[AW+1:0];
    size_n = size;
    case (size)
      2'b00:   ;
      2'b01:   addr_n[0] = 1'b0;
      default: begin
        addr_n[1:0] = 2'b00;
        size_n      = 2'b10;
      end
    endcase
  end
`endif

  always_comb begin
    word_rd = mem[addr_q[AW+1:2]];
    be      = '0;
    wr_val  = '0;
    ld_val  = '0;
    case (size_q)
      2'b00: begin
        be           = 4'b0001 << addr_q[1:0];
        wr_val       = {4{wdata_q[7:0]}};
        ld_val       = word_rd >> {addr_q[1:0], 3'b000};
        ld_val[31:8] = {24{~lu_q & ld_val[7]}};
      end
      2'b01: begin
        be            = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_val        = {2{wdata_q[15:0]}};
        ld_val        = word_rd >> {addr_q[1], 4'b0000};
        ld_val[31:16] = {16{~lu_q & ld_val[15]}};
      end
      default: begin
        be     = '1;
        wr_val = wdata_q;
        ld_val = word_rd;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    lu_d       = lu_q;
    wr_d       = wr_q;
    rdata_d    = rdata_q;
    rdata      = rdata_q;
    stall      = 1'b0;
    done       = 1'b0;
    misaligned = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        misaligned = req & bad;
        if (req && !bad) begin
          stall   = 1'b1;
          state_d = ACCESS;
          cnt_d   = CW'(WAIT_CYCLES - 1);
          addr_d  = addr_n;
          wdata_d = wdata;
          size_d  = size_n;
          lu_d    = load_unsigned;
          wr_d    = mem_write;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          mem_we  = wr_q;
          if (!wr_q) rdata_d = ld_val;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
        if (wr_q) rdata = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      lu_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      lu_q    <= lu_d;
      wr_q    <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wr_val[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: vector table, reset-abort sequence,
// and randomized traffic against a byte-addressed reference model.
module tb_data_mem_unit;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        mem_read, mem_write, load_unsigned;
  logic [1:0]  size;
  logic        stall, done, misaligned;

  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [7:0] mb [4096];

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  sz;
    bit          lu;
    logic [31:0] exp;
    bit          mis;
  } vec_t;

  vec_t tbl [$];

  data_mem_unit #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .mem_read(mem_read), .mem_write(mem_write), .size(size),
    .load_unsigned(load_unsigned), .rdata(rdata), .stall(stall),
    .done(done), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit wr, bit rd, logic [31:0] a, logic [31:0] wd,
                              logic [1:0] sz, bit lu, logic [31:0] exp, bit mis);
    vec_t v;
    v.wr = wr; v.rd = rd; v.a = a; v.wd = wd; v.sz = sz; v.lu = lu;
    v.exp = exp; v.mis = mis;
    return v;
  endfunction

  function automatic int nb(logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [11:0] eff(logic [31:0] a, logic [1:0] sz);
    logic [11:0] e;
    e = a[11:0];
`ifndef DMEM_MISALIGN_TRAP_EN
    if (sz == 2'd1) e[0] = 1'b0;
    else if (sz >= 2'd2) e[1:0] = 2'b00;
`endif
    return e;
  endfunction

  function automatic bit mis_of(logic [31:0] a, logic [1:0] sz);
`ifdef DMEM_MISALIGN_TRAP_EN
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] a, logic [1:0] sz, bit lu);
    logic [31:0] v;
    logic [11:0] e;
    int n;
    v = '0;
    e = eff(a, sz);
    n = nb(sz);
    for (int k = 0; k < n; k++) v = v | (32'(mb[e + 12'(k)]) << (8 * k));
    if (!lu && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic model_store(logic [31:0] a, logic [31:0] wd, logic [1:0] sz);
    logic [11:0] e;
    e = eff(a, sz);
    for (int k = 0; k < nb(sz); k++) mb[e + 12'(k)] = wd[8*k +: 8];
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic txn(bit wr, bit rd, logic [31:0] a, logic [31:0] wd, logic [1:0] sz,
                     bit lu, logic [31:0] exp, bit exp_mis, string nm);
    @(negedge clk);
    mem_write = wr; mem_read = rd; addr = a; wdata = wd; size = sz; load_unsigned = lu;
    #1;
    chk({nm, " misaligned"}, 32'(misaligned), 32'(exp_mis));
    chk({nm, " stall req"}, 32'(stall), 32'(!exp_mis));
    if (exp_mis) begin
      @(negedge clk);
      #1;
      chk({nm, " no done"}, 32'(done), 32'd0);
      chk({nm, " no stall"}, 32'(stall), 32'd0);
      mem_read = 1'b0; mem_write = 1'b0;
      return;
    end
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      addr = $urandom; wdata = $urandom; size = 2'($urandom); load_unsigned = 1'($urandom);
      #1;
      chk({nm, " stall access"}, 32'(stall), 32'd1);
      chk({nm, " done early"}, 32'(done), 32'd0);
    end
    @(negedge clk);
    addr = a; wdata = wd; size = sz; load_unsigned = lu;
    #1;
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " stall done"}, 32'(stall), 32'd0);
    chk({nm, " rdata"}, rdata, exp);
    if (wr) model_store(a, wd, sz);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    chk({nm, " done cleared"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    addr = '0; wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
    size = 2'd0; load_unsigned = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset rdata", rdata, 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset misaligned", 32'(misaligned), 32'd0);
    rst = 1'b0;

    tbl.push_back(mk(1, 0, 32'h10, 32'hDEADBEEF, 2'd2, 0, 32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h10, 32'h0, 2'd2, 0, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 0, 32'h13, 32'h0000005A, 2'd0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h10, 32'h0, 2'd2, 0, 32'h5AADBEEF, 0));
    tbl.push_back(mk(1, 0, 32'h13, 32'h12345680, 2'd0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h13, 32'h0, 2'd0, 0, 32'hFFFFFF80, 0));
    tbl.push_back(mk(0, 1, 32'h13, 32'h0, 2'd0, 1, 32'h00000080, 0));
`ifdef DMEM_MISALIGN_TRAP_EN
    tbl.push_back(mk(0, 1, 32'h11, 32'h0, 2'd1, 0, 32'h0, 1));
`else
    tbl.push_back(mk(0, 1, 32'h11, 32'h0, 2'd1, 0, 32'hFFFFBEEF, 0));
`endif
    tbl.push_back(mk(0, 1, 32'h10, 32'h0, 2'd2, 0, 32'h80ADBEEF, 0));
    tbl.push_back(mk(1, 0, 32'h12, 32'hAAAA7FFF, 2'd1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h12, 32'h0, 2'd1, 0, 32'h00007FFF, 0));
    tbl.push_back(mk(0, 1, 32'h11, 32'h0, 2'd0, 1, 32'h000000BE, 0));
    tbl.push_back(mk(0, 1, 32'h10, 32'h0, 2'd0, 0, 32'hFFFFFFEF, 0));
`ifdef DMEM_MISALIGN_TRAP_EN
    tbl.push_back(mk(0, 1, 32'h12, 32'h0, 2'd3, 0, 32'h0, 1));
`else
    tbl.push_back(mk(0, 1, 32'h12, 32'h0, 2'd3, 0, 32'h7FFFBEEF, 0));
`endif
    tbl.push_back(mk(1, 1, 32'h08, 32'h11223344, 2'd2, 0, 32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h08, 32'h0, 2'd2, 0, 32'h11223344, 0));
    tbl.push_back(mk(1, 0, 32'h20, 32'h0, 2'd2, 0, 32'h0, 0));
    tbl.push_back(mk(1, 0, 32'h00001004, 32'hCAFEF00D, 2'd2, 0, 32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h00000004, 32'h0, 2'd2, 0, 32'hCAFEF00D, 0));

    for (int i = 0; i < tbl.size(); i++)
      txn(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].wd, tbl[i].sz, tbl[i].lu,
          tbl[i].exp, tbl[i].mis, $sformatf("vec%0d", i));

    // Reset during the second ACCESS cycle of a word store aborts it.
    @(negedge clk);
    mem_write = 1'b1; addr = 32'h20; wdata = 32'h12345678; size = 2'd2;
    #1;
    chk("abort stall req", 32'(stall), 32'd1);
    @(negedge clk);
    #1;
    chk("abort stall access1", 32'(stall), 32'd1);
    @(negedge clk);
    rst = 1'b1; mem_write = 1'b0;
    #1;
    chk("abort rdata", rdata, 32'd0);
    chk("abort stall", 32'(stall), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort misaligned", 32'(misaligned), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    txn(0, 1, 32'h20, 32'h0, 2'd2, 0, 32'h0, 0, "abort readback");

    for (int w = 0; w < 16; w++)
      txn(1, 0, 32'h40 + 32'(4 * w), 32'h0, 2'd2, 0, 32'h0, 0, "init");

    for (int t = 0; t < 60; t++) begin
      logic [31:0] a, wd, exp;
      logic [1:0]  sz;
      bit          lu, wr, rd, m;
      int          op;
      op = $urandom_range(0, 2);
      wr = (op != 0);
      rd = (op != 1);
      a  = ($urandom & 32'hFFFF_F000) | (32'h40 + 32'($urandom_range(0, 15)) * 4) |
           32'($urandom_range(0, 3));
      wd = $urandom;
      sz = 2'($urandom_range(0, 3));
      lu = 1'($urandom);
      m  = mis_of(a, sz);
      exp = wr ? 32'h0 : model_load(a, sz, lu);
      txn(wr, rd, a, wd, sz, lu, exp, m, $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
